// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: boot-loads an instruction memory, then round-robins its single port between fetch and loader
//   clk, rst        clock, asynchronous active-low reset
//   f_valid/f_addr  fetch request (byte address), f_ready accept
//   r_valid/r_data  fetch response one cycle after accept, r_err flags misaligned/out-of-range fetches
//   l_valid/l_addr  loader word write with l_data, l_ready accept, l_done ends the boot image
//   core_rst_n      CPU hold, released from the first RUN cycle
//   load_count      accepted loader writes since reset, saturating at 2^ADDR_W
//   mem_*           single-port memory: en/we/addr/wdata out, rdata valid one cycle after a read
module instr_mem_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_valid,
   input  logic [31:0]       f_addr,
   output logic              f_ready,
   output logic              r_valid,
   output logic [DATA_W-1:0] r_data,
   output logic              r_err,
   input  logic              l_valid,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_data,
   output logic              l_ready,
   input  logic              l_done,
   output logic              core_rst_n,
   output logic [ADDR_W:0]   load_count,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic {BOOT, RUN} state_t;
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
   state_t state;
   logic last_fetch;
   logic f_bad, f_acc, l_acc;
   // misaligned, or a byte address beyond the memory's depth
   assign f_bad = (|f_addr[1:0]) || ((f_addr >> (ADDR_W + 2)) != 32'd0);
   // each ready looks only at the other side's valid, never at its ready
   assign f_ready = rst && state == RUN && (!l_valid || !last_fetch);
   assign l_ready = rst && (state == BOOT || !f_valid || last_fetch);
   assign f_acc = f_valid && f_ready;
   assign l_acc = l_valid && l_ready;
   assign mem_en = l_acc || (f_acc && !f_bad);
   assign mem_we = l_acc;
   assign mem_addr = l_acc ? l_addr : f_addr[ADDR_W+1:2];
   assign mem_wdata = l_data;
   assign r_data = (r_valid && !r_err) ? mem_rdata : '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= BOOT;
         core_rst_n <= 1'b0;
         last_fetch <= 1'b0;
         r_valid <= 1'b0;
         r_err <= 1'b0;
         load_count <= '0;
      end else begin
         if (state == BOOT && l_done) begin
            state <= RUN;
            core_rst_n <= 1'b1;
         end
         if (state == RUN && (f_acc || l_acc)) last_fetch <= f_acc;
         r_valid <= f_acc;
         r_err <= f_acc && f_bad;
         if (l_acc && load_count != CNT_MAX) load_count <= load_count + (ADDR_W+1)'(1);
      end
   end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: randomized self-checking bench against a behavioural boot/arbitration/memory model
module tb_instr_mem_ctrl;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic f_valid = 1'b0;
   logic [31:0] f_addr = '0;
   logic f_ready, r_valid, r_err;
   logic [DW-1:0] r_data;
   logic l_valid = 1'b0;
   logic [AW-1:0] l_addr = '0;
   logic [DW-1:0] l_data = '0;
   logic l_ready;
   logic l_done = 1'b0;
   logic core_rst_n;
   logic [AW:0] load_count;
   logic mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] env_mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   int checks = 0;
   int failures = 0;
   bit m_run, m_last_f, pv, perr, e_f, e_l, e_bad;
   int m_count;
   logic [DW-1:0] pdata;

   instr_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
      .r_valid(r_valid), .r_data(r_data), .r_err(r_err),
      .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready), .l_done(l_done),
      .core_rst_n(core_rst_n), .load_count(load_count),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else mem_rdata <= env_mem[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      f_valid = 1'b0;
      l_valid = 1'b0;
      l_done = 1'b0;
   endtask

   task automatic model_reset;
      m_run = 1'b0;
      m_last_f = 1'b0;
      m_count = 0;
      pv = 1'b0;
      perr = 1'b0;
      pdata = '0;
   endtask

   // which requesters the rules say are granted this cycle
   task automatic predict;
      e_bad = (f_addr % 4 != 0) || (f_addr >= 32'(4 * DEPTH));
      if (!m_run) begin
         e_l = l_valid;
         e_f = 1'b0;
      end else if (f_valid && l_valid) begin
         e_f = !m_last_f;
         e_l = m_last_f;
      end else begin
         e_f = f_valid;
         e_l = l_valid;
      end
   endtask

   // advance the model across the clock edge
   task automatic commit;
      pv = e_f;
      perr = e_f && e_bad;
      pdata = (e_f && !e_bad) ? ref_mem[int'(f_addr >> 2)] : '0;
      if (e_l) begin
         ref_mem[l_addr] = l_data;
         if (m_count < DEPTH) m_count++;
      end
      if (m_run && (e_f || e_l)) m_last_f = e_f;
      if (!m_run && l_done) m_run = 1'b1;
   endtask

   function automatic logic [31:0] rand_faddr();
      int sel = $urandom_range(0, 7);
      logic [31:0] w = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      if (sel == 0) return w + 32'($urandom_range(1, 3));
      if (sel == 1) return $urandom | 32'h0000_1000;
      return w;
   endfunction

   task automatic test_reset;
      model_reset();
      f_valid = 1'b1;
      l_valid = 1'b1;
      #1 rst = 1'b0;
      #3;
      checks++;
      if ({f_ready, l_ready, mem_en, mem_we} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctl act=%b req=0000", {f_ready, l_ready, mem_en, mem_we});
      end
      checks++;
      if ({core_rst_n, r_valid, r_err} !== 3'b0) begin
         failures++;
         $display("FAIL reset_flags act=%b req=000", {core_rst_n, r_valid, r_err});
      end
      checks++;
      if (r_data !== '0 || load_count !== '0) begin
         failures++;
         $display("FAIL reset_data act=%h/%0d req=0/0", r_data, load_count);
      end
      idle();
   endtask

   task automatic test_boot;
      logic [DW-1:0] img [2];
      img[0] = 32'h00500293;
      img[1] = 32'h00F28313;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         l_valid = 1'b1;
         l_addr = AW'(i);
         l_data = img[i];
         f_valid = 1'b1;
         f_addr = 32'(i * 4);
         predict();
         #3;
         checks++;
         if ({l_ready, f_ready, mem_en, mem_we, core_rst_n} !== 5'b10110) begin
            failures++;
            $display("FAIL boot_ctl act=%b req=10110", {l_ready, f_ready, mem_en, mem_we, core_rst_n});
         end
         checks++;
         if (mem_addr !== AW'(i) || mem_wdata !== img[i]) begin
            failures++;
            $display("FAIL boot_wr act=%0d:%h req=%0d:%h", mem_addr, mem_wdata, i, img[i]);
         end
         tick();
         commit();
         checks++;
         if (r_valid !== 1'b0 || load_count !== (AW+1)'(m_count)) begin
            failures++;
            $display("FAIL boot_cnt act=%b/%0d req=0/%0d", r_valid, load_count, m_count);
         end
      end
      l_valid = 1'b0;
      l_done = 1'b1;
      predict();
      #3;
      checks++;
      if (f_ready !== 1'b0 || core_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL boot_done_pre act=%b%b req=00", f_ready, core_rst_n);
      end
      tick();
      commit();
      checks++;
      if (core_rst_n !== 1'b1 || load_count !== (AW+1)'(2) || r_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_done act=%b/%0d/%b req=1/2/0", core_rst_n, load_count, r_valid);
      end
      idle();
   endtask

   task automatic test_contention;
      int nf = 0;
      int nl = 0;
      for (int i = 0; i < 6; i++) begin
         f_valid = 1'b1;
         l_valid = 1'b1;
         f_addr = 32'($urandom_range(0, 9)) * 32'd4;
         l_addr = AW'($urandom_range(10, DEPTH - 1));
         l_data = $urandom;
         predict();
         #3;
         checks++;
         if ({f_ready, l_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL contend_gnt%0d act=%b req=%b", i, {f_ready, l_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         nf += int'(f_ready);
         nl += int'(l_ready);
         tick();
         commit();
         checks++;
         if (r_valid !== pv || r_data !== pdata) begin
            failures++;
            $display("FAIL contend_rsp%0d act=%b:%h req=%b:%h", i, r_valid, r_data, pv, pdata);
         end
      end
      checks++;
      if (nf != 3 || nl != 3) begin
         failures++;
         $display("FAIL contend_total act=%0d/%0d req=3/3", nf, nl);
      end
      idle();
   endtask

   task automatic test_fetch;
      f_valid = 1'b1;
      f_addr = 32'h4;
      predict();
      #3;
      checks++;
      if ({f_ready, mem_en, mem_we} !== 3'b110 || mem_addr !== AW'(1)) begin
         failures++;
         $display("FAIL fetch_req act=%b@%0d req=110@1", {f_ready, mem_en, mem_we}, mem_addr);
      end
      tick();
      commit();
      idle();
      checks++;
      if (r_valid !== 1'b1 || r_err !== 1'b0 || r_data !== 32'h00F28313) begin
         failures++;
         $display("FAIL fetch_rsp act=%b%b:%h req=10:00f28313", r_valid, r_err, r_data);
      end
   endtask

   task automatic test_errors;
      logic [31:0] bad [2];
      bad[0] = 32'h2;
      bad[1] = 32'h1000;
      for (int i = 0; i < 2; i++) begin
         f_valid = 1'b1;
         f_addr = bad[i];
         predict();
         #3;
         checks++;
         if (f_ready !== 1'b1 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL err_req%0d act=%b%b req=10", i, f_ready, mem_en);
         end
         tick();
         commit();
         idle();
         checks++;
         if (r_valid !== 1'b1 || r_err !== 1'b1 || r_data !== '0) begin
            failures++;
            $display("FAIL err_rsp%0d act=%b%b:%h req=11:0", i, r_valid, r_err, r_data);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 24; i++) begin
         f_valid = 1'b1;
         f_addr = (i % 5 == 4) ? rand_faddr() : 32'($urandom_range(0, 9)) * 32'd4;
         predict();
         #3;
         checks++;
         if (f_ready !== 1'b1 || mem_en !== !e_bad) begin
            failures++;
            $display("FAIL b2b_req%0d act=%b%b req=1%b", i, f_ready, mem_en, !e_bad);
         end
         tick();
         commit();
         checks++;
         if (r_valid !== 1'b1 || r_err !== perr || r_data !== pdata) begin
            failures++;
            $display("FAIL b2b_rsp%0d act=%b%b:%h req=1%b:%h", i, r_valid, r_err, r_data, perr, pdata);
         end
      end
      idle();
      predict();
      tick();
      commit();
      checks++;
      if (r_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_tail act=%b req=0", r_valid);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         f_valid = 1'($urandom_range(0, 1));
         l_valid = 1'($urandom_range(0, 1));
         l_done = ($urandom_range(0, 9) == 0);
         f_addr = rand_faddr();
         l_addr = AW'($urandom_range(2, DEPTH - 1));
         l_data = $urandom;
         predict();
         #3;
         checks++;
         if ({f_ready && f_valid, l_ready && l_valid} !== {e_f, e_l} || (f_ready && l_ready && f_valid && l_valid)) begin
            failures++;
            $display("FAIL rand_gnt%0d act=%b%b req=%b%b", i, f_ready && f_valid, l_ready && l_valid, e_f, e_l);
         end
         checks++;
         if ({mem_en, mem_we} !== {e_l || (e_f && !e_bad), e_l}) begin
            failures++;
            $display("FAIL rand_memctl%0d act=%b%b req=%b%b", i, mem_en, mem_we, e_l || (e_f && !e_bad), e_l);
         end
         checks++;
         if ((e_l && (mem_addr !== l_addr || mem_wdata !== l_data)) || (e_f && !e_bad && mem_addr !== AW'(f_addr >> 2))) begin
            failures++;
            $display("FAIL rand_memaddr%0d act=%0d:%h", i, mem_addr, mem_wdata);
         end
         tick();
         commit();
         checks++;
         if (r_valid !== pv || r_err !== perr || r_data !== pdata) begin
            failures++;
            $display("FAIL rand_rsp%0d act=%b%b:%h req=%b%b:%h", i, r_valid, r_err, r_data, pv, perr, pdata);
         end
         checks++;
         if (load_count !== (AW+1)'(m_count) || core_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL rand_cnt%0d act=%0d/%b req=%0d/1", i, load_count, core_rst_n, m_count);
         end
      end
      idle();
   endtask

   task automatic test_saturation;
      for (int i = 0; i < DEPTH + 20; i++) begin
         l_valid = 1'b1;
         l_addr = AW'($urandom_range(2, DEPTH - 1));
         l_data = $urandom;
         predict();
         tick();
         commit();
      end
      idle();
      checks++;
      if (load_count !== (AW+1)'(DEPTH) || m_count != DEPTH) begin
         failures++;
         $display("FAIL sat_cnt act=%0d req=%0d", load_count, DEPTH);
      end
   endtask

   task automatic test_simul_done;
      rst = 1'b0;
      model_reset();
      tick();
      rst = 1'b1;
      l_valid = 1'b1;
      l_addr = AW'(5);
      l_data = $urandom;
      l_done = 1'b1;
      f_valid = 1'b1;
      f_addr = 32'h0;
      predict();
      #3;
      checks++;
      if ({l_ready, f_ready, mem_en, mem_we} !== 4'b1011 || mem_addr !== AW'(5)) begin
         failures++;
         $display("FAIL simul_wr act=%b@%0d req=1011@5", {l_ready, f_ready, mem_en, mem_we}, mem_addr);
      end
      tick();
      commit();
      checks++;
      if (load_count !== (AW+1)'(1) || core_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL simul_state act=%0d/%b req=1/1", load_count, core_rst_n);
      end
      l_valid = 1'b0;
      l_done = 1'b0;
      predict();
      #3;
      checks++;
      if (f_ready !== 1'b1) begin
         failures++;
         $display("FAIL simul_run act=%b req=1", f_ready);
      end
      tick();
      commit();
      idle();
   endtask

   task automatic test_reset_mid;
      f_valid = 1'b1;
      f_addr = 32'h4;
      predict();
      #3;
      checks++;
      if (f_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_accept act=%b req=1", f_ready);
      end
      tick();
      rst = 1'b0;
      l_valid = 1'b1;
      model_reset();
      #2;
      checks++;
      if ({r_valid, r_err, core_rst_n, f_ready, l_ready, mem_en, mem_we} !== 7'b0 || r_data !== '0 || load_count !== '0) begin
         failures++;
         $display("FAIL mid_reset act=%b:%h/%0d req=0000000:0/0", {r_valid, r_err, core_rst_n, f_ready, l_ready, mem_en, mem_we}, r_data, load_count);
      end
      tick();
      idle();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         predict();
         tick();
         commit();
         checks++;
         if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after%0d act=%b req=0", i, r_valid);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      test_reset();
      test_boot();
      test_contention();
      test_fetch();
      test_errors();
      test_back_to_back();
      test_random();
      test_saturation();
      test_simul_done();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the instruction memory (depth 2^ADDR_W words).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 f_valid  input  1  fetch request valid.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_ready  output  1  fetch request accepted this cycle when high with f_valid.
REQ-008 r_valid  output  1  fetch response valid, one cycle.
REQ-009 r_data  output  DATA_W  fetch response instruction word.
REQ-010 r_err  output  1  fetch response error flag, qualified by r_valid.
REQ-011 l_valid  input  1  loader write valid.
REQ-012 l_addr  input  ADDR_W  loader word address.
REQ-013 l_data  input  DATA_W  loader write data.
REQ-014 l_ready  output  1  loader write accepted when high with l_valid.
REQ-015 l_done  input  1  loader end-of-image pulse.
REQ-016 core_rst_n  output  1  active-low hold for the CPU core.
REQ-017 load_count  output  ADDR_W+1  number of accepted loader writes since reset.
REQ-018 mem_en, mem_we  output  1 each  memory port enable, write enable.
REQ-019 mem_addr  output  ADDR_W  memory word address.
REQ-020 mem_wdata  output  DATA_W  memory write data.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after a read with mem_en=1, mem_we=0.

Function
REQ-022 FSM states: BOOT, RUN; BOOT after reset.
REQ-023 BOOT: l_ready=1, f_ready=0, core_rst_n=0; accepted loader write drives mem_en=1, mem_we=1, mem_addr=l_addr, mem_wdata=l_data same cycle.
REQ-024 BOOT -> RUN on l_done=1; a write accepted in the same cycle as l_done is performed; core_rst_n=1 from the first RUN cycle.
REQ-025 RUN: single memory port shared by fetch and loader, one grant per cycle, combinational grant.
REQ-026 RUN arbitration: round-robin; when both valid, grant the requester not granted most recently; sole valid requester always granted; last-grant pointer resets to "loader".
REQ-027 Fetch grant: mem_en=1, mem_we=0, mem_addr=f_addr[ADDR_W+1:2]; r_valid=1 next cycle with r_data=mem_rdata, r_err=0.
REQ-028 Fetch with f_addr[1:0]!=0 or f_addr[31:ADDR_W+2]!=0: accepted (f_ready=1), no memory access (mem_en=0), r_valid=1 next cycle with r_err=1, r_data=0; counts as a fetch grant for round-robin.
REQ-029 Back-to-back fetches sustain one accept per cycle; r_valid follows each accept by exactly one cycle, in order.
REQ-030 l_done in RUN is ignored; FSM never returns to BOOT except by reset.
REQ-031 load_count increments on each accepted loader write (BOOT or RUN), saturates at 2^ADDR_W.
REQ-032 Idle cycles: mem_en=0, mem_we=0; mem_addr, mem_wdata don't-care.
REQ-033 Ready outputs do not depend on the other requester's ready; f_ready and l_ready never both 1 in RUN when both valid.

Reset
REQ-034 rst=0 asynchronously forces: state BOOT, core_rst_n=0, r_valid=0, r_err=0, r_data=0, load_count=0, last-grant=loader, mem_en=0, mem_we=0.
REQ-035 Reset mid-operation: an accepted fetch whose response is pending is dropped; no r_valid after rst release until a new accept.
REQ-036 During rst=0, f_ready=0 and l_ready=0.

Verification
REQ-037 Boot: release rst, write 0x00500293 to addr 0 and 0x00F28313 to addr 1, pulse l_done -> load_count=2, core_rst_n=1 next cycle, no fetch accepted before.
REQ-038 Fetch: RUN, f_addr=0x4 -> mem_addr=1, r_valid next cycle, r_data=0x00F28313, r_err=0.
REQ-039 Errors: f_addr=0x2 and f_addr=0x1000 (ADDR_W=10) -> each r_valid with r_err=1, r_data=0, mem_en=0.
REQ-040 Contention: f_valid and l_valid held high 6 cycles in RUN -> grants alternate loader/fetch, starting fetch (pointer=loader after reset), 3 each.
REQ-041 Simultaneous l_valid+l_done in BOOT -> write performed, count increments, state RUN next cycle.
REQ-042 Reset mid-fetch: accept fetch, assert rst=0 same following cycle -> r_valid stays 0, outputs at REQ-034 values.
